// File: rtl/closed_list_writer.sv
// Closed-list write side for the A* planner: appends (x,y) nodes and serves indexed reads.
// Optional macro CLOSED_DUP_CHECK_EN enables a linear duplicate scan before each store.
module closed_list_writer #(
  parameter int DEPTH   = 400,
  parameter int IDX_W   = 9,
  parameter int COORD_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [COORD_W-1:0] wr_x_i,
  input  logic [COORD_W-1:0] wr_y_i,
  output logic               wr_ack_o,
  output logic               wr_dup_o,
  output logic               overflow_o,
  input  logic               clear_i,
  input  logic [IDX_W-1:0]   rd_index_i,
  output logic [COORD_W-1:0] rd_x_o,
  output logic [COORD_W-1:0] rd_y_o,
  output logic               rd_hit_o,
  output logic [IDX_W-1:0]   count_o,
  output logic               full_o
);

  localparam logic [IDX_W-1:0] DEPTH_L = IDX_W'(DEPTH);

`ifdef CLOSED_DUP_CHECK_EN
  typedef enum logic [1:0] {IDLE, WRITE, SCAN} state_t;
`else
  typedef enum logic {IDLE, WRITE} state_t;
`endif

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic [COORD_W-1:0] xLat_q, xLat_d, yLat_q, yLat_d;
  logic [COORD_W-1:0] rdX_q, rdY_q;
  logic               rdHit_q;
  logic               memWe, wrAck, wrDup, overflow;
  logic [COORD_W-1:0] memX [DEPTH];
  logic [COORD_W-1:0] memY [DEPTH];
`ifdef CLOSED_DUP_CHECK_EN
  logic [IDX_W-1:0]   scanIdx_q, scanIdx_d;
`endif

  assign wr_ready_o = (state_q == IDLE) && !full_q && !clear_i;

  // clear overrides everything, including acknowledging an in-flight insert
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    xLat_d   = xLat_q;
    yLat_d   = yLat_q;
    memWe    = 1'b0;
    wrAck    = 1'b0;
    wrDup    = 1'b0;
    overflow = 1'b0;
`ifdef CLOSED_DUP_CHECK_EN
    scanIdx_d = scanIdx_q;
`endif
    if (clear_i) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_valid_i) begin
            if (full_q) begin
              overflow = 1'b1;
            end else begin
              xLat_d = wr_x_i;
              yLat_d = wr_y_i;
`ifdef CLOSED_DUP_CHECK_EN
              scanIdx_d = '0;
              state_d   = (count_q == '0) ? WRITE : SCAN;
`else
              state_d = WRITE;
`endif
            end
          end
        end
        WRITE: begin
          if (count_q != DEPTH_L) begin
            memWe   = 1'b1;
            count_d = count_q + 1'b1;
          end
          wrAck   = 1'b1;
          state_d = IDLE;
        end
`ifdef CLOSED_DUP_CHECK_EN
        SCAN: begin
          if (memX[scanIdx_q] == xLat_q && memY[scanIdx_q] == yLat_q) begin
            wrAck   = 1'b1;
            wrDup   = 1'b1;
            state_d = IDLE;
          end else if (scanIdx_q + 1'b1 == count_q) begin
            state_d = WRITE;
          end else begin
            scanIdx_d = scanIdx_q + 1'b1;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
    full_d = (count_d == DEPTH_L);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      count_q <= '0;
      full_q  <= 1'b0;
      xLat_q  <= '0;
      yLat_q  <= '0;
`ifdef CLOSED_DUP_CHECK_EN
      scanIdx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= full_d;
      xLat_q  <= xLat_d;
      yLat_q  <= yLat_d;
`ifdef CLOSED_DUP_CHECK_EN
      scanIdx_q <= scanIdx_d;
`endif
    end
  end

  // storage is deliberately unreset; entries at or beyond count are don't-care
  always_ff @(posedge clk_i) begin
    if (memWe) begin
      memX[count_q] <= xLat_q;
      memY[count_q] <= yLat_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdX_q   <= '0;
      rdY_q   <= '0;
      rdHit_q <= 1'b0;
    end else begin
      rdHit_q <= (rd_index_i < count_q);
      if (rd_index_i < DEPTH_L) begin
        rdX_q <= memX[rd_index_i];
        rdY_q <= memY[rd_index_i];
      end else begin
        rdX_q <= '0;
        rdY_q <= '0;
      end
    end
  end

  assign wr_ack_o   = wrAck;
`ifdef CLOSED_DUP_CHECK_EN
  assign wr_dup_o   = wrDup;
`else
  assign wr_dup_o   = 1'b0;
`endif
  assign overflow_o = overflow;
  assign rd_x_o     = rdX_q;
  assign rd_y_o     = rdY_q;
  assign rd_hit_o   = rdHit_q;
  assign count_o    = count_q;
  assign full_o     = full_q;

endmodule

// File: tb/tb_closed_list_writer.sv
// Self-checking bench for closed_list_writer against a queue-based model of the closed list.
// Honours CLOSED_DUP_CHECK_EN to choose between store-always and drop-duplicate expectations.
module tb_closed_list_writer;

  localparam int DEPTH   = 400;
  localparam int IDX_W   = 9;
  localparam int COORD_W = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               wr_valid;
  logic               wr_ready;
  logic [COORD_W-1:0] wr_x, wr_y;
  logic               wr_ack, wr_dup, overflow, clear;
  logic [IDX_W-1:0]   rd_index;
  logic [COORD_W-1:0] rd_x, rd_y;
  logic               rd_hit;
  logic [IDX_W-1:0]   count;
  logic               full;

  int total = 0;
  int bad   = 0;

  logic [COORD_W-1:0] modelX[$];
  logic [COORD_W-1:0] modelY[$];

  closed_list_writer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .COORD_W(COORD_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_x_i(wr_x), .wr_y_i(wr_y),
    .wr_ack_o(wr_ack), .wr_dup_o(wr_dup), .overflow_o(overflow),
    .clear_i(clear), .rd_index_i(rd_index),
    .rd_x_o(rd_x), .rd_y_o(rd_y), .rd_hit_o(rd_hit),
    .count_o(count), .full_o(full)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit modelHas(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    for (int i = 0; i < modelX.size(); i++)
      if (modelX[i] == x && modelY[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  // full insert handshake: wait for ready, transfer, wait for ack, check count afterwards
  task automatic applyStimulus(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    bit expDup;
    bit gotReady = 0;
    bit gotAck = 0;
`ifdef CLOSED_DUP_CHECK_EN
    expDup = modelHas(x, y);
`else
    expDup = 1'b0;
`endif
    wr_valid = 1'b1;
    wr_x = x;
    wr_y = y;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (wr_ready) begin gotReady = 1; break; end
      tick();
    end
    if (!gotReady) begin
      checkOutput("ready_timeout", 32'd0, 32'd1);
      wr_valid = 1'b0;
      return;
    end
    tick();
    wr_valid = 1'b0;
    for (int c = 0; c < DEPTH + 10; c++) begin
      if (wr_ack) begin gotAck = 1; break; end
      tick();
    end
    checkOutput("ack_seen", 32'(gotAck), 32'd1);
    if (!gotAck) return;
    checkOutput("wr_dup", 32'(wr_dup), 32'(expDup));
    if (!expDup) begin
      modelX.push_back(x);
      modelY.push_back(y);
    end
    tick();
    checkOutput("count_after_insert", 32'(count), 32'(modelX.size()));
  endtask

  task automatic readCheck(input int idx);
    bit expHit;
    rd_index = IDX_W'(idx);
    tick();
    expHit = (idx < modelX.size());
    checkOutput("rd_hit", 32'(rd_hit), 32'(expHit));
    if (idx >= DEPTH) begin
      checkOutput("rd_x_oob", 32'(rd_x), 32'd0);
      checkOutput("rd_y_oob", 32'(rd_y), 32'd0);
    end else if (expHit) begin
      checkOutput("rd_x", 32'(rd_x), 32'(modelX[idx]));
      checkOutput("rd_y", 32'(rd_y), 32'(modelY[idx]));
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_x = '0; wr_y = '0; clear = 1'b0; rd_index = '0;

    // reset state
    tick();
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_ack", 32'(wr_ack), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_rd_hit", 32'(rd_hit), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_rst", 32'(wr_ready), 32'd1);

    // reset asserted while an insert is in flight
    applyStimulus(8'd11, 8'd12);
    wr_valid = 1'b1; wr_x = 8'd1; wr_y = 8'd2;
    tick();
    wr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_count", 32'(count), 32'd0);
    checkOutput("midrst_ack", 32'(wr_ack), 32'd0);
    modelX.delete(); modelY.delete();
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("midrst_ready", 32'(wr_ready), 32'd1);
    tick();
    checkOutput("midrst_ack_later", 32'(wr_ack), 32'd0);
    checkOutput("midrst_count_later", 32'(count), 32'd0);

    // two inserts and read-back
    applyStimulus(8'd3, 8'd5);
    applyStimulus(8'd7, 8'd1);
    readCheck(1);
    readCheck(0);
    readCheck(2);

    // duplicate insert
    applyStimulus(8'd3, 8'd5);
    readCheck(modelX.size() - 1);

    // random inserts with a narrow coordinate range so duplicates occur
    for (int i = 0; i < 25; i++)
      applyStimulus(8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
    for (int i = 0; i < 8; i++)
      readCheck($urandom_range(0, 40));

    // clear during the ack cycle of an insert: no ack, list emptied
    wr_valid = 1'b1; wr_x = 8'hAA; wr_y = 8'h55;
    #1;
    for (int c = 0; c < DEPTH + 10 && !wr_ready; c++) tick();
    tick();
    wr_valid = 1'b0;
    for (int c = 0; c < DEPTH + 10 && !wr_ack; c++) begin
      clear = 1'b0;
      tick();
    end
    clear = 1'b1;
    #1;
    checkOutput("clear_inflight_ack", 32'(wr_ack), 32'd0);
    tick();
    clear = 1'b0;
    modelX.delete(); modelY.delete();
    checkOutput("clear_inflight_count", 32'(count), 32'd0);
    checkOutput("clear_inflight_noack", 32'(wr_ack), 32'd0);

`ifndef CLOSED_DUP_CHECK_EN
    // fill to capacity; the duplicate scan makes this impractically long with the macro set
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(8'($urandom), 8'($urandom));
      if (i == DEPTH - 2) begin
        checkOutput("full_at_depth_minus1", 32'(full), 32'd0);
        checkOutput("ready_at_depth_minus1", 32'(wr_ready), 32'd1);
      end
    end
    checkOutput("full_set", 32'(full), 32'd1);
    checkOutput("ready_when_full", 32'(wr_ready), 32'd0);
    wr_valid = 1'b1; wr_x = 8'd9; wr_y = 8'd9;
    #1;
    checkOutput("overflow_pulse", 32'(overflow), 32'd1);
    tick();
    checkOutput("overflow_count", 32'(count), 32'(DEPTH));
    checkOutput("overflow_held", 32'(overflow), 32'd1);
    checkOutput("overflow_no_ack", 32'(wr_ack), 32'd0);
    wr_valid = 1'b0;
    #1;
    checkOutput("overflow_drop", 32'(overflow), 32'd0);
    readCheck(0);
    readCheck(DEPTH - 1);
    readCheck(DEPTH);
    readCheck(511);
    for (int i = 0; i < 6; i++)
      readCheck($urandom_range(0, DEPTH - 1));
`else
    for (int i = 0; i < 5; i++)
      applyStimulus(8'($urandom), 8'($urandom));
    readCheck(DEPTH);
`endif

    // clear coincident with wr_valid: request refused, list empties
    clear = 1'b1; wr_valid = 1'b1; wr_x = 8'd4; wr_y = 8'd4;
    #1;
    checkOutput("clear_ready", 32'(wr_ready), 32'd0);
    tick();
    clear = 1'b0; wr_valid = 1'b0;
    modelX.delete(); modelY.delete();
    #1;
    checkOutput("clear_count", 32'(count), 32'd0);
    checkOutput("clear_full", 32'(full), 32'd0);
    checkOutput("clear_no_ack", 32'(wr_ack), 32'd0);
    tick();
    checkOutput("clear_no_ack_later", 32'(wr_ack), 32'd0);
    applyStimulus(8'd21, 8'd34);
    readCheck(0);
    readCheck(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
